// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU definitions: opcode encodings and sequencer FSM state encodings,
// also used by the downstream ALU control decoder.
package alu_op_sequencer_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_SRA     = 3'b010,
    OP_SRL     = 3'b011,
    OP_SLL     = 3'b100,
    OP_AND     = 3'b101,
    OP_OR      = 3'b110,
    OP_ILLEGAL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and result handshake signals of the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, res_ready,
    output cmd_ready, op, alu_a, alu_b, res_valid, res_data, res_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, res_ready,
    input  cmd_ready, op, alu_a, alu_b, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), head visible combinationally
// so the sequencer can decode the opcode in the same cycle it pops.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, issues them one at a time to an external combinational
// ALU and returns results in order over a valid/ready handshake.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int ENTRY_W = OP_W + 2 * WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] head_entry;
  logic [OP_W-1:0]    head_op;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  seq_state_e       state_reg,     state_next;
  logic [OP_W-1:0]  op_reg,        op_next;
  logic [WIDTH-1:0] alu_a_reg,     alu_a_next;
  logic [WIDTH-1:0] alu_b_reg,     alu_b_next;
  logic             res_valid_reg, res_valid_next;
  logic [WIDTH-1:0] res_data_reg,  res_data_next;
  logic             res_err_reg,   res_err_next;

  assign fifo_push = bus.cmd_valid & ~fifo_full;

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_op = head_entry[ENTRY_W-1 -: OP_W];
  assign head_a  = head_entry[2*WIDTH-1 -: WIDTH];
  assign head_b  = head_entry[WIDTH-1:0];

  // Ready is held low throughout reset, then follows the registered occupancy.
  assign bus.cmd_ready = rst_n && (fifo_count != CNT_W'(DEPTH));
  assign bus.op        = op_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_err   = res_err_reg;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    res_err_next   = res_err_reg;
    fifo_pop       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_legal_op(head_op)) begin
            op_next    = head_op;
            alu_a_next = head_a;
            alu_b_next = head_b;
            state_next = ST_ISSUE;
          end else begin
            // Illegal opcodes never reach the ALU; answer straight away.
            res_data_next  = '0;
            res_err_next   = 1'b1;
            res_valid_next = 1'b1;
            state_next     = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        res_data_next  = bus.alu_y;
        res_err_next   = 1'b0;
        res_valid_next = 1'b1;
        state_next     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          res_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_err_reg   <= res_err_next;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer against a transaction-level
// model (command queue, result latency rules, in-order scoreboard).
module tb_alu_op_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return $unsigned($signed(a) >>> b[4:0]);
      3'd3:    return a >> b[4:0];
      3'd4:    return a << b[4:0];
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // External combinational ALU
  always_comb bus.alu_y = alu_ref(bus.op, bus.alu_a, bus.alu_b);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  // Model: queued commands, expected result outputs and last issued ALU drive.
  cmd_t        mq[$];
  logic [32:0] got_q[$];
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_issue = 1'b0;
  logic [31:0] m_data  = '0;
  logic [2:0]  m_op    = '0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;

  always @(negedge clk) begin : compare
    cmd_t c;
    cmd_t c_in;
    bit   push;
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0; m_err = 1'b0; m_issue = 1'b0; m_data = '0;
      m_op = '0; m_a = '0; m_b = '0;
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_err", bus.res_err, 0);
      chk("rst_op", bus.op, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
    end else begin
      chk("cmd_ready", bus.cmd_ready, (mq.size() < DEPTH));
      chk("res_valid", bus.res_valid, m_valid);
      if (m_valid) begin
        chk("res_data", bus.res_data, m_data);
        chk("res_err", bus.res_err, m_err);
      end
      chk("op", bus.op, m_op);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      push = bus.cmd_valid && (mq.size() < DEPTH);
      c_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
      if (m_issue) begin
        m_data  = alu_ref(m_op, m_a, m_b);
        m_err   = 1'b0;
        m_valid = 1'b1;
        m_issue = 1'b0;
      end else if (m_valid) begin
        if (bus.res_ready) begin
          got_q.push_back({bus.res_err, bus.res_data});
          m_valid = 1'b0;
        end
      end else if (mq.size() > 0) begin
        c = mq.pop_front();
        if (c.op == 3'b111) begin
          m_valid = 1'b1; m_err = 1'b1; m_data = '0;
        end else begin
          m_op = c.op; m_a = c.a; m_b = c.b; m_issue = 1'b1;
        end
      end
      if (push) mq.push_back(c_in);
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after acceptance.
  task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit r;
    bit ok;
    ok = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("push_accept_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (mq.size() == 0 && !m_valid && !m_issue) begin
        done = 1;
        break;
      end
    end
    chk("wait_idle_timeout", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          base;
    int          accepted;
    bit          r;
    logic [31:0] exp_q[$];
    logic [31:0] fa;
    logic [31:0] fb;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.res_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd_ready", bus.cmd_ready, 0);
    chk("async_rst_res_valid", bus.res_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD 5+3: pop one cycle after acceptance, result two cycles after pop
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 32'd5; bus.cmd_b = 32'd3;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("add_n0_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("add_issue_op", bus.op, 3'd0);
    chk("add_issue_a", bus.alu_a, 32'd5);
    chk("add_issue_b", bus.alu_b, 32'd3);
    chk("add_issue_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("add_valid", bus.res_valid, 1);
    chk("add_data", bus.res_data, 32'd8);
    chk("add_err", bus.res_err, 0);
    wait_idle();

    // Illegal opcode: error one cycle after pop, ALU drive untouched
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_a = 32'd7; bus.cmd_b = 32'd7;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("ill_n0_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("ill_valid", bus.res_valid, 1);
    chk("ill_err", bus.res_err, 1);
    chk("ill_data", bus.res_data, 0);
    chk("ill_op_kept", bus.op, 3'd0);
    chk("ill_a_kept", bus.alu_a, 32'd5);
    chk("ill_b_kept", bus.alu_b, 32'd3);
    wait_idle();

    // SUB then SRA back-to-back, results in order
    base = got_q.size();
    push_cmd(3'd1, 32'd3, 32'd5);
    push_cmd(3'd2, 32'h8000_0000, 32'd4);
    wait_idle();
    chk("subsra_count", got_q.size() - base, 2);
    if (got_q.size() - base >= 2) begin
      chk("sub_result", got_q[base], {1'b0, 32'hFFFF_FFFE});
      chk("sra_result", got_q[base+1], {1'b0, 32'hF800_0000});
    end

    // Back-pressure: 1 in RESP plus DEPTH queued, then stall
    bus.res_ready = 1'b0;
    base = got_q.size();
    accepted = 0;
    fa = $urandom; fb = $urandom;
    for (int i = 0; i < 20; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'(accepted % 7); bus.cmd_a = fa; bus.cmd_b = fb;
      @(negedge clk);
      r = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        exp_q.push_back(alu_ref(3'(accepted % 7), fa, fb));
        accepted++;
        fa = $urandom; fb = $urandom;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("fill_accepted", accepted, DEPTH + 1);
    @(negedge clk);
    chk("fill_ready_low", bus.cmd_ready, 0);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    wait_idle();
    chk("fill_result_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      chk("fill_result", got_q[base+i], {1'b0, exp_q[i]});
    end

    // Randomised traffic, checked every cycle by the compare process
    base = got_q.size();
    for (int i = 0; i < 600; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 3'($urandom_range(0, 7));
      bus.cmd_a     = $urandom;
      bus.cmd_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle();
    chk("random_traffic_flowed", (got_q.size() - base) > 20, 1);

    // Reset while a command is in ISSUE with two more queued
    bus.res_ready = 1'b0;
    push_cmd(3'd0, 32'd1, 32'd2);
    push_cmd(3'd0, 32'd3, 32'd4);
    push_cmd(3'd0, 32'd5, 32'd6);
    push_cmd(3'd0, 32'd7, 32'd8);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_issue_a", bus.alu_a, 32'd3);
    chk("pre_rst_issue_valid", bus.res_valid, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    chk("mid_rst_op", bus.op, 0);
    chk("mid_rst_alu_a", bus.alu_a, 0);
    chk("mid_rst_alu_b", bus.alu_b, 0);
    chk("mid_rst_res_data", bus.res_data, 0);
    chk("mid_rst_res_err", bus.res_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", bus.res_valid, 0);
    end
    @(posedge clk);
    #1;
    base = got_q.size();
    push_cmd(3'd6, 32'h0000_00F0, 32'h0000_000F);
    wait_idle();
    chk("post_rst_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("post_rst_or", got_q[base], {1'b0, 32'h0000_00FF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
